// File: rtl/stego_extract.sv
// Recovers message bytes from one carrier bit per pixel byte (MSB first),
// XOR-decrypts each byte with a cycling key and emits it over a ready/valid port.
module stego_extract #(
  parameter int unsigned BIT_POS = 2,
  parameter int unsigned KEY_LEN = 26
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [11:0] msg_len,
  input  logic        pix_valid,
  input  logic [7:0]  pix_data,
  output logic        pix_ready,
  output logic [7:0]  key_addr,
  input  logic [7:0]  key_data,
  output logic        out_valid,
  output logic [7:0]  out_data,
  input  logic        out_ready,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, COLLECT, EMIT, DONE} state_t;

  localparam logic [7:0] KEY_LAST = 8'(KEY_LEN - 1);

  state_t      state, state_next;
  logic [6:0]  shift;
  logic [2:0]  bit_cnt;
  logic [11:0] byte_cnt;
  logic [11:0] len;
  logic [7:0]  key_idx;
  logic        pix_bit;
  logic [7:0]  next_byte;
  logic        accept;
  logic        emit_hs;
  logic        run_start;

  // Mask-and-reduce keeps the whole pixel byte in the expression.
  assign pix_bit   = |(pix_data & (8'd1 << BIT_POS));
  assign next_byte = {shift, pix_bit};
  assign accept    = (state == COLLECT) && pix_valid;
  assign emit_hs   = (state == EMIT) && out_ready;
  assign run_start = ((state == IDLE) || (state == DONE)) && start;
  assign key_addr  = key_idx;

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: if (start) state_next = (msg_len != '0) ? COLLECT : DONE;
      COLLECT:    if (accept && (bit_cnt == 3'd7)) state_next = EMIT;
      EMIT:       if (out_ready) state_next = ((byte_cnt + 12'd1) == len) ? DONE : COLLECT;
      default:    state_next = IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      shift     <= '0;
      bit_cnt   <= '0;
      byte_cnt  <= '0;
      len       <= '0;
      key_idx   <= '0;
      out_data  <= '0;
      pix_ready <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_next;
      pix_ready <= (state_next == COLLECT);
      out_valid <= (state_next == EMIT);
      busy      <= (state_next == COLLECT) || (state_next == EMIT);
      done      <= (state_next == DONE);

      if (run_start && (msg_len != '0)) begin
        len      <= msg_len;
        shift    <= '0;
        bit_cnt  <= '0;
        byte_cnt <= '0;
        key_idx  <= '0;
      end

      if (accept) begin
        shift   <= next_byte[6:0];
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) out_data <= next_byte ^ key_data;
      end

      if (emit_hs) begin
        byte_cnt <= byte_cnt + 12'd1;
        key_idx  <= (key_idx == KEY_LAST) ? '0 : key_idx + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_stego_extract.sv
// Directed bench for stego_extract: a queue of expected bytes and key indices
// is filled as pixels are driven and drained at each output handshake.
module tb_stego_extract;

  localparam int unsigned BP = 2;
  localparam int unsigned KL = 26;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [11:0] msg_len;
  logic        pix_valid;
  logic [7:0]  pix_data;
  logic        pix_ready;
  logic [7:0]  key_addr;
  logic [7:0]  key_data;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready;
  logic        busy;
  logic        done;

  logic [7:0]  key_mem [0:255];
  logic [7:0]  exp_q [$];
  logic [7:0]  kexp_q [$];
  int unsigned kidx;
  int unsigned passed = 0;
  int unsigned total  = 0;

  assign key_data = key_mem[key_addr];

  stego_extract #(.BIT_POS(BP), .KEY_LEN(KL)) dut (
    .clk(clk), .reset(reset), .start(start), .msg_len(msg_len),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
    .key_addr(key_addr), .key_data(key_data),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  // Scoreboard drain at every output handshake.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", 32'(out_data), 32'hFFFF_FFFF);
      end else begin
        check("out_data", 32'(out_data), 32'(exp_q.pop_front()));
        check("key_addr_hs", 32'(key_addr), 32'(kexp_q.pop_front()));
      end
    end
  end

  // All tasks enter and leave just after a rising edge.
  task automatic cycles(input int unsigned n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic start_run(input logic [11:0] len);
    start = 1'b1; msg_len = len;
    @(posedge clk); #1;
    start = 1'b0;
    kidx = 0;
  endtask

  task automatic send_pix(input logic b);
    bit acc = 1'b0;
    int unsigned n = 0;
    pix_data = 8'($urandom);
    pix_data[BP] = b;
    pix_valid = 1'b1;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = pix_ready;
      @(posedge clk); #1;
      n++;
    end
    pix_valid = 1'b0;
    pix_data = 8'($urandom);
    if (!acc) check("pix_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_byte(input logic [7:0] cipher, input int unsigned gap);
    logic [7:0] expv;
    expv = cipher ^ key_mem[kidx];
    exp_q.push_back(expv);
    kexp_q.push_back(8'(kidx));
    kidx = (kidx == KL - 1) ? 0 : kidx + 1;
    for (int i = 7; i >= 0; i--) begin
      send_pix(cipher[i]);
      if (i != 0 && gap != 0) cycles(gap);
    end
    @(negedge clk);
    check("latency_out_valid", 32'(out_valid), 32'd1);
    check("latency_out_data", 32'(out_data), 32'(expv));
    @(posedge clk); #1;
  endtask

  task automatic wait_done(input string tag);
    int unsigned n = 0;
    while (!done && n < 100) begin @(negedge clk); n++; end
    check(tag, 32'(done), 32'd1);
    check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) key_mem[i] = 8'h00;
    reset = 1'b1; start = 1'b0; msg_len = '0; pix_valid = 1'b0;
    pix_data = '0; out_ready = 1'b1; kidx = 0;
    #12;
    check("rst_pix_ready", 32'(pix_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_key_addr", 32'(key_addr), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    cycles(2);

    // Basic extract: key 0x00, bits 0x41.
    start_run(12'd1);
    check("busy_collect", 32'(busy), 32'd1);
    send_byte(8'h41, 0);
    wait_done("basic_done");
    check("done_pix_ready", 32'(pix_ready), 32'd0);
    check("done_out_valid", 32'(out_valid), 32'd0);

    // Decryption with output backpressure.
    key_mem[0] = 8'h5A;
    out_ready = 1'b0;
    start_run(12'd1);
    send_byte(8'h1B, 0);
    pix_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_out_data", 32'(out_data), 32'h41);
      check("bp_pix_ready", 32'(pix_ready), 32'd0);
      @(posedge clk); #1;
    end
    pix_valid = 1'b0;
    out_ready = 1'b1;
    wait_done("bp_done");

    // Input gaps across two bytes.
    key_mem[1] = 8'hC3;
    start_run(12'd2);
    send_byte(8'h96, 2);
    send_byte(8'h3C, 1);
    wait_done("gap_done");

    // Key wrap over 28 bytes.
    for (int i = 0; i < int'(KL); i++) key_mem[i] = 8'(i * 37 + 5);
    start_run(12'd28);
    for (int b = 0; b < 28; b++) send_byte(8'($urandom), 0);
    wait_done("wrap_done");

    // Zero length.
    start_run(12'd0);
    check("zero_done", 32'(done), 32'd1);
    pix_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("zero_pix_ready", 32'(pix_ready), 32'd0);
      check("zero_busy", 32'(busy), 32'd0);
      @(posedge clk); #1;
    end
    pix_valid = 1'b0;

    // Reset mid-byte, then a clean run.
    key_mem[0] = 8'h00;
    start_run(12'd1);
    send_pix(1'b1); send_pix(1'b1); send_pix(1'b0);
    #2 reset = 1'b1;
    #1;
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_pix_ready", 32'(pix_ready), 32'd0);
    cycles(2);
    reset = 1'b0;
    cycles(1);
    start_run(12'd1);
    send_byte(8'h41, 0);
    wait_done("rst_rerun_done");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    check("global_timeout", 32'd0, 32'd1);
    $display("%0d/%0d checks passed", passed, total);
    $fatal(1, "FAIL global_timeout");
  end

endmodule

// File: doc/stego_extract.md
STEGO_EXTRACT -- requirements
Module: stego_extract

Interface
REQ-001 Parameter BIT_POS, default 2: pixel-byte bit position that carries one message bit.
REQ-002 Parameter KEY_LEN, default 26: key length in bytes; key index range 0..KEY_LEN-1.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 reset  in  1  reset, asynchronous, active-high.
REQ-005 start  in  1  single-cycle pulse; begins an extraction run.
REQ-006 msg_len  in  12  number of message bytes to recover; sampled on accepted start.
REQ-007 pix_valid  in  1  pix_data holds a valid stego pixel byte.
REQ-008 pix_data  in  8  stego pixel byte, one colour channel.
REQ-009 pix_ready  out  1  block accepts pix_data this cycle.
REQ-010 key_addr  out  8  current key byte index.
REQ-011 key_data  in  8  key byte at key_addr; combinational read, valid in the same cycle.
REQ-012 out_valid  out  1  out_data holds a recovered plaintext byte.
REQ-013 out_data  out  8  recovered plaintext byte.
REQ-014 out_ready  in  1  downstream accepts out_data.
REQ-015 busy  out  1  high in COLLECT or EMIT.
REQ-016 done  out  1  high in DONE.

Function
REQ-017 FSM states: IDLE, COLLECT, EMIT, DONE.
REQ-018 IDLE or DONE, start=1, msg_len>0: go to COLLECT; clear bit counter, byte counter and key index.
REQ-019 IDLE or DONE, start=1, msg_len=0: go to DONE; no pixels consumed; no bytes emitted.
REQ-020 start is ignored in COLLECT and EMIT.
REQ-021 pix_ready is 1 only in COLLECT; a pixel is accepted only on a cycle with pix_valid=1 and pix_ready=1.
REQ-022 Per accepted pixel: shift register <= {shift[6:0], pix_data[BIT_POS]} (first bit = MSB); 3-bit bit counter increments.
REQ-023 On the 8th accepted pixel of a byte:
  - out_data <= {shift[6:0], pix_data[BIT_POS]} XOR key_data
  - bit counter wraps to 0
  - go to EMIT
  - latency: out_valid high on the cycle after the 8th pixel is accepted.
REQ-024 In EMIT: out_valid=1; out_data holds stable until out_valid=1 and out_ready=1 in the same cycle.
REQ-025 On the EMIT handshake: byte counter increments; key index goes from KEY_LEN-1 to 0, otherwise increments.
REQ-026 After the EMIT handshake: if byte counter = msg_len, go to DONE; otherwise go to COLLECT.
REQ-027 key_addr = key index at all times; key index changes only on an EMIT handshake or a run start.
REQ-028 In DONE: done=1, held until an accepted start or reset; pix_ready=0; out_valid=0.
REQ-029 In IDLE: all outputs 0 except key_addr=0.
REQ-030 Counter widths: byte counter 12 bit; key index 8 bit; no other arithmetic.

Reset
REQ-031 reset=1 forces, regardless of clk:
  - state IDLE
  - shift register, bit counter, byte counter, key index = 0
  - pix_ready, out_valid, out_data, busy, done = 0
REQ-032 reset mid-run abandons the run, including any partial byte; the next start begins from a clean state with no residue.

Verification
REQ-033 Basic extract: KEY_LEN=26, key_data=0x00, msg_len=1, 8 pixels with bit2 = 0,1,0,0,0,0,0,1 (e.g. 0x00,0x04,0x00,0x00,0x00,0x00,0x00,0x04) -> out_data=0x41 one cycle after the 8th pixel; done=1 after the handshake.
REQ-034 Decryption: key_data=0x5A, pixel bits encode 0x1B -> out_data=0x41.
REQ-035 Backpressure and gaps:
  - out_ready held 0 for 5 cycles -> out_valid and out_data stay stable; pix_ready=0 throughout.
  - pix_valid gaps during COLLECT -> no bits lost.
REQ-036 Key wrap: msg_len=28 -> key_addr sequence 0..25, 0, 1 across the 28 bytes; done after the 28th handshake.
REQ-037 Zero length: start with msg_len=0 -> done=1 next cycle; pix_ready never asserts.
REQ-038 Reset mid-byte: reset after 3 pixels of byte 0, then start with msg_len=1 and the REQ-033 pixels -> out_data=0x41.
